intersection_controller: RTL and testbench



---
 rtl/intersection_controller.sv | 134 +++++++++++++
 tb/tb_intersection_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer with internal phase timer and request latches.
// Optional pedestrian walk phase is enabled by defining INTERSECTION_PED_EN.
module intersection_controller #(
    parameter int CNT_W       = 16,
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 8,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int WALK_TIME   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ns_sensor,
    input  logic             ew_sensor,
`ifdef INTERSECTION_PED_EN
    input  logic             ped_request,
`endif
    output logic             ns_red,
    output logic             ns_green,
    output logic             ns_yellow,
    output logic             ew_red,
    output logic             ew_green,
    output logic             ew_yellow,
`ifdef INTERSECTION_PED_EN
    output logic             walk,
`endif
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam longint MAX_DUR = (longint'(1) << CNT_W) - 1;

    if (CNT_W < 1 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_TIME < 1 ||
        ALLRED_TIME < 1 || WALK_TIME < 1 || longint'(GREEN_MAX) > MAX_DUR ||
        longint'(YELLOW_TIME) > MAX_DUR || longint'(ALLRED_TIME) > MAX_DUR ||
        longint'(WALK_TIME) > MAX_DUR) begin : g_bad_params
        $error("intersection_controller: illegal duration parameters");
    end

    localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_TIME - 1);
`ifdef INTERSECTION_PED_EN
    localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_TIME - 1);
`endif

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        WALK      = 3'd6
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] elapsed;
    logic             ew_req;
    logic             ped_req;
    logic             ns_sensor_unused;

    assign ns_sensor_unused = ns_sensor;

`ifndef INTERSECTION_PED_EN
    assign ped_req = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            NS_GREEN:  if (elapsed >= GMIN_END && (ew_req || ew_sensor || ped_req)) nxt = NS_YELLOW;
            NS_YELLOW: if (elapsed == YELLOW_END) nxt = ALL_RED_A;
            ALL_RED_A: if (elapsed == ALLRED_END) nxt = EW_GREEN;
            EW_GREEN:  if (elapsed >= GMIN_END && (!ew_sensor || elapsed == GMAX_END)) nxt = EW_YELLOW;
            EW_YELLOW: if (elapsed == YELLOW_END) nxt = ALL_RED_B;
            ALL_RED_B: if (elapsed == ALLRED_END) nxt = ped_req ? WALK : NS_GREEN;
`ifdef INTERSECTION_PED_EN
            WALK:      if (elapsed == WALK_END) nxt = NS_GREEN;
`endif
            default:   nxt = ALL_RED_B;
        endcase
    end

    // Lights are registered from the next state so they line up with phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ALL_RED_B;
            elapsed   <= '0;
            ew_req    <= 1'b0;
            ns_red    <= 1'b1;
            ns_green  <= 1'b0;
            ns_yellow <= 1'b0;
            ew_red    <= 1'b1;
            ew_green  <= 1'b0;
            ew_yellow <= 1'b0;
`ifdef INTERSECTION_PED_EN
            ped_req   <= 1'b0;
            walk      <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (nxt != state)
                elapsed <= '0;
            else if (elapsed != '1)
                elapsed <= elapsed + 1'b1;

            if (nxt == EW_GREEN && state != EW_GREEN)
                ew_req <= 1'b0;
            else if (ew_sensor && state != EW_GREEN)
                ew_req <= 1'b1;

            ns_green  <= (nxt == NS_GREEN);
            ns_yellow <= (nxt == NS_YELLOW);
            ns_red    <= !(nxt == NS_GREEN || nxt == NS_YELLOW);
            ew_green  <= (nxt == EW_GREEN);
            ew_yellow <= (nxt == EW_YELLOW);
            ew_red    <= !(nxt == EW_GREEN || nxt == EW_YELLOW);
`ifdef INTERSECTION_PED_EN
            if (nxt == WALK && state != WALK)
                ped_req <= 1'b0;
            else if (ped_request && state != WALK)
                ped_req <= 1'b1;
            walk <= (nxt == WALK);
`endif
        end
    end

    assign phase     = state;
    assign phase_cnt = elapsed;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: per-cycle comparison against a table-driven
// phase model plus directed phase-sequence checks (pedestrian part under INTERSECTION_PED_EN).
module tb_intersection_controller;

    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YT   = 2;
    localparam int AR   = 1;
    localparam int WT   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ns_sensor;
    logic        ew_sensor;
    logic        ped_request;
    logic        ns_red, ns_green, ns_yellow;
    logic        ew_red, ew_green, ew_yellow;
    logic        walk_s;
    logic [2:0]  phase;
    logic [15:0] phase_cnt;

    int vectors     = 0;
    int miscompares = 0;

    intersection_controller #(
        .CNT_W(16), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_TIME(YT), .ALLRED_TIME(AR), .WALK_TIME(WT)
    ) dut (
        .clock(clock), .reset(reset), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
`ifdef INTERSECTION_PED_EN
        .ped_request(ped_request), .walk(walk_s),
`endif
        .ns_red(ns_red), .ns_green(ns_green), .ns_yellow(ns_yellow),
        .ew_red(ew_red), .ew_green(ew_green), .ew_yellow(ew_yellow),
        .phase(phase), .phase_cnt(phase_cnt)
    );

`ifndef INTERSECTION_PED_EN
    assign walk_s = 1'b0;
`endif

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase number + elapsed count, fixed phases ended by a duration table.
    int dur[7]  = '{0, YT, AR, 0, YT, AR, WT};
    int succ[7] = '{1, 2, 3, 4, 5, 0, 0};
    int m_ph, m_el;
    bit m_ew, m_ped, m_valid = 0;

    always @(posedge clock) begin
        int nx;
        m_valid = 1;
        if (reset) begin
            m_ph = 5; m_el = 0; m_ew = 0; m_ped = 0;
        end else begin
            nx = m_ph;
            if (m_ph == 0) begin
                if (m_el >= GMIN - 1 && (m_ew || ew_sensor || m_ped)) nx = 1;
            end else if (m_ph == 3) begin
                if (m_el >= GMIN - 1 && (!ew_sensor || m_el == GMAX - 1)) nx = 4;
            end else if (m_ph == 5) begin
                if (m_el == AR - 1) nx = m_ped ? 6 : 0;
            end else if (m_el == dur[m_ph] - 1) begin
                nx = succ[m_ph];
            end
`ifdef INTERSECTION_PED_EN
            if (nx == 6 && m_ph != 6) m_ped = 0;
            else if (ped_request && m_ph != 6) m_ped = 1;
`endif
            if (nx == 3 && m_ph != 3) m_ew = 0;
            else if (ew_sensor && m_ph != 3) m_ew = 1;
            m_el = (nx != m_ph) ? 0 : (m_el == 65535 ? 65535 : m_el + 1);
            m_ph = nx;
        end
    end

    always @(negedge clock) begin
        logic [31:0] act, exp;
        logic ng, ny, eg, ey;
        if (m_valid) begin
            ng = (m_ph == 0); ny = (m_ph == 1);
            eg = (m_ph == 3); ey = (m_ph == 4);
            exp = {5'd0, 3'(m_ph), 16'(m_el), !(ng || ny), ng, ny, !(eg || ey), eg, ey,
                   (m_ph == 6), m_ew};
            act = {5'd0, phase, phase_cnt, ns_red, ns_green, ns_yellow,
                   ew_red, ew_green, ew_yellow, walk_s, dut.ew_req};
            check("cycle_model", act, exp);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_state(input int ph, input int cnt, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (phase == 3'(ph) && phase_cnt == 16'(cnt)) break;
            @(negedge clock);
        end
        check("wait_state", {13'd0, phase, phase_cnt}, {13'd0, 3'(ph), 16'(cnt)});
    endtask

    int seq1[15] = '{0,0,0,1,1,2,3,3,3,3,4,4,5,0,0};
    int seq2[24] = '{0,0,0,0,1,1,2,3,3,3,3,3,3,3,3,4,4,5,0,0,0,0,1,1};
`ifdef INTERSECTION_PED_EN
    int seq3[19] = '{0,0,0,0,1,1,2,3,3,3,3,4,4,5,6,6,6,0,0};
`endif

    initial begin
        reset = 1'b1; ns_sensor = 1'b0; ew_sensor = 1'b0; ped_request = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("reset_lights", {30'd0, ns_red, ew_red}, 32'h3);
            check("reset_phase", 32'(phase), 32'd5);
            check("reset_cnt", 32'(phase_cnt), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        check("release_phase", 32'(phase), 32'd0);
        check("release_ns_green", 32'(ns_green), 32'd1);

        // Idle: NS green holds forever, counter runs
        ns_sensor = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("idle_cnt", 32'(phase_cnt), 32'(i));
            check("idle_lights", {26'd0, phase, ns_green, ew_red, ns_yellow},
                  {26'd0, 3'd0, 1'b1, 1'b1, 1'b0});
            @(negedge clock);
        end
        ns_sensor = 1'b0;

        // Single-cycle EW pulse at NS elapsed=1
        do_reset();
        @(negedge clock);
        check("pulse_start_cnt", 32'(phase_cnt), 32'd1);
        for (int i = 0; i < 15; i++) begin
            check("pulse_seq", 32'(phase), 32'(seq1[i]));
            ew_sensor = (i == 0);
            @(negedge clock);
        end

        // EW sensor held: EW green runs to maximum, NS green minimum
        do_reset();
        ew_sensor = 1'b1;
        for (int i = 0; i < 24; i++) begin
            check("held_seq", 32'(phase), 32'(seq2[i]));
            @(negedge clock);
        end

        // Reset in mid EW green: straight to all-red, no yellow
        wait_state(3, 2, 40);
        reset = 1'b1;
        ew_sensor = 1'b0;
        @(negedge clock);
        check("midreset_phase", 32'(phase), 32'd5);
        check("midreset_lights", {28'd0, ew_red, ew_yellow, ew_green, dut.ew_req}, 32'h8);
        reset = 1'b0;

`ifdef INTERSECTION_PED_EN
        do_reset();
        ped_request = 1'b1;
        for (int i = 0; i < 19; i++) begin
            check("ped_seq", 32'(phase), 32'(seq3[i]));
            if (i >= 14 && i <= 16)
                check("walk_lights", {29'd0, walk_s, ns_red, ew_red}, 32'h7);
            ped_request = 1'b0;
            @(negedge clock);
        end
        check("ped_req_cleared", {30'd0, dut.ped_req, walk_s}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
